// File: rtl/sdpram_bist.sv
// Built-in self test for a simple dual-port RAM: fill with a pattern, read back,
// compare against a latency-matched expected pipeline, report pass/errors/first fail.
module sdpram_bist #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int BE_WIDTH   = 1,
  parameter int RD_LATENCY = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [BE_WIDTH-1:0]   mem_wr_byte_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DRN_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [DRN_W-1:0]      DRN_LAST  = DRN_W'(RD_LATENCY - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
  logic [1:0]            mode_q, mode_d;
  logic [DRN_W-1:0]      drain_q, drain_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ERR_CNT_W-1:0]  err_q, err_d;
  logic [ADDR_WIDTH-1:0] ffa_q, ffa_d;
  logic                  ff_q, ff_d;
  logic                  mismatch;

  logic                  pv_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pd_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] pa_q [RD_LATENCY];

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] ax;
    logic [DATA_WIDTH-1:0] cb;
    ax = DATA_WIDTH'(a);
    for (int i = 0; i < DATA_WIDTH; i++) cb[i] = ~i[0];
    if (a[0]) cb = ~cb;
    case (m)
      2'd0:    pattern = ~ax;
      2'd1:    pattern = ax;
      2'd2:    pattern = cb;
      default: pattern = ~cb;
    endcase
  endfunction

  assign addr_inc = addr_q + 1'b1;
  assign mismatch = pv_q[RD_LATENCY-1] && (mem_rd_data != pd_q[RD_LATENCY-1]);

  // start is a request accepted only in IDLE or DONE; done then holds until the
  // next accepted start, so a controller may pulse or level-hold start freely.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    drain_d   = drain_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    ffa_d     = ffa_q;
    ff_d      = ff_q;

    if (mismatch) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (!ff_q) begin
        ff_d  = 1'b1;
        ffa_d = pa_q[RD_LATENCY-1];
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_WRITE;
          addr_d    = '0;
          mode_d    = mode;
          wr_en_d   = 1'b1;
          wr_data_d = pattern(mode, '0);
          err_d     = '0;
          ffa_d     = '0;
          ff_d      = 1'b0;
        end
      end
      S_WRITE: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_READ;
          addr_d  = '0;
          rd_en_d = 1'b1;
        end else begin
          addr_d    = addr_inc;
          wr_en_d   = 1'b1;
          wr_data_d = pattern(mode_q, addr_inc);
        end
      end
      S_READ: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          addr_d  = addr_inc;
          rd_en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRN_LAST) state_d = S_DONE;
        else                     drain_d = drain_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      mode_q    <= 2'd0;
      drain_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_data_q <= '0;
      err_q     <= '0;
      ffa_q     <= '0;
      ff_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      drain_q   <= drain_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      ffa_q     <= ffa_d;
      ff_q      <= ff_d;
    end
  end

  // Expected-data pipeline: stage 0 captures the read presented on the port,
  // the last stage lines up with the RAM's returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) pv_q[i] <= 1'b0;
    end else begin
      pv_q[0] <= rd_en_q;
      for (int i = 1; i < RD_LATENCY; i++) pv_q[i] <= pv_q[i-1];
    end
    pd_q[0] <= pattern(mode_q, addr_q);
    pa_q[0] <= addr_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pd_q[i] <= pd_q[i-1];
      pa_q[i] <= pa_q[i-1];
    end
  end

  assign busy            = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign pass            = done && (err_q == '0);
  assign err_cnt         = err_q;
  assign first_fail_addr = ffa_q;
  assign mem_wr_en       = wr_en_q;
  assign mem_wr_addr     = addr_q;
  assign mem_wr_data     = wr_data_q;
  assign mem_wr_byte_en  = '1;
  assign mem_rd_en       = rd_en_q;
  assign mem_rd_addr     = addr_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_sdpram_bist.sv
// Directed bench for sdpram_bist: one instance with RD_LATENCY=2/ERR_CNT_W=3 and
// one with RD_LATENCY=1/ERR_CNT_W=8, both on 16x8 behavioural RAMs sharing stimulus.
module tb_sdpram_bist;

  logic       clk, rst, start;
  logic [1:0] mode;
  int         fault;
  int         total = 0;
  int         bad = 0;

  logic       busy2, done2, pass2, we2, re2;
  logic [2:0] err2, st2;
  logic [3:0] ffa2, wa2, ra2;
  logic [7:0] wd2, rd2, r2_s1;
  logic [0:0] be2;

  logic       busy1, done1, pass1, we1, re1;
  logic [7:0] err1;
  logic [2:0] st1;
  logic [3:0] ffa1, wa1, ra1;
  logic [7:0] wd1, rd1;
  logic [0:0] be1;

  logic [7:0] mem2 [16];
  logic [7:0] mem1 [16];

  sdpram_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .BE_WIDTH(1), .RD_LATENCY(2), .ERR_CNT_W(3)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .first_fail_addr(ffa2), .mem_wr_en(we2), .mem_wr_addr(wa2), .mem_wr_data(wd2),
    .mem_wr_byte_en(be2), .mem_rd_en(re2), .mem_rd_addr(ra2), .mem_rd_data(rd2), .dbg_state(st2));

  sdpram_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .BE_WIDTH(1), .RD_LATENCY(1), .ERR_CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_fail_addr(ffa1), .mem_wr_en(we1), .mem_wr_addr(wa1), .mem_wr_data(wd1),
    .mem_wr_byte_en(be1), .mem_rd_en(re1), .mem_rd_addr(ra1), .mem_rd_data(rd1), .dbg_state(st1));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM models ----------------
  function automatic logic [7:0] fdata(input logic [7:0] v, input logic [3:0] a);
    if (fault == 1 && a == 4'd5) return v & 8'hFE;
    if (fault == 2) return 8'h00;
    return v;
  endfunction

  always @(posedge clk) begin
    if (we2) mem2[wa2] <= wd2;
    if (re2) r2_s1 <= fdata(mem2[ra2], ra2);
    rd2 <= r2_s1;
    if (we1) mem1[wa1] <= wd1;
    if (re1) rd1 <= fdata(mem1[ra1], ra1);
  end

  // ---------------- driver tasks ----------------
  // Returns at the sampling point of cycle 1 (first cycle after the start edge E0).
  task automatic kick(input logic [1:0] m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Starting at cycle n0, records the first cycle each instance shows done (0 = timeout).
  task automatic wait_done(input int n0, output int d2, output int d1);
    int n;
    n  = n0;
    d2 = 0;
    d1 = 0;
    while (n < 120 && (d2 == 0 || d1 == 0)) begin
      if (done2 && d2 == 0) d2 = n;
      if (done1 && d1 == 0) d1 = n;
      if (d2 == 0 || d1 == 0) begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({busy2, done2, pass2, we2, re2} !== 5'b0) begin bad++; $display("FAIL reset_ctl2 got=%b want=00000", {busy2, done2, pass2, we2, re2}); end
    total++; if ({busy1, done1, pass1, we1, re1} !== 5'b0) begin bad++; $display("FAIL reset_ctl1 got=%b want=00000", {busy1, done1, pass1, we1, re1}); end
    total++; if (err2 !== 3'd0 || ffa2 !== 4'd0) begin bad++; $display("FAIL reset_err2 got=%0h/%0h want=0/0", err2, ffa2); end
    total++; if (err1 !== 8'd0 || ffa1 !== 4'd0) begin bad++; $display("FAIL reset_err1 got=%0h/%0h want=0/0", err1, ffa1); end
    total++; if (wa2 !== 4'd0 || ra2 !== 4'd0 || wd2 !== 8'd0) begin bad++; $display("FAIL reset_bus2 got=%0h/%0h/%0h want=0/0/0", wa2, ra2, wd2); end
    total++; if (be2 !== 1'b1 || be1 !== 1'b1) begin bad++; $display("FAIL reset_be got=%b%b want=11", be2, be1); end
    total++; if (st2 !== 3'd0 || st1 !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d/%0d want=0/0", st2, st1); end
    rst = 1'b0;
  endtask

  task automatic test_mode0();
    int d2, d1;
    kick(2'd0);
    for (int n = 1; n <= 32; n++) begin
      total++;
      if (n <= 16) begin
        if (!(we2 === 1'b1 && re2 === 1'b0 && wa2 === 4'(n - 1) && wd2 === 8'(255 - (n - 1)))) begin
          bad++; $display("FAIL m0_write cyc=%0d got we=%b addr=%0h data=%0h want we=1 addr=%0h data=%0h",
                          n, we2, wa2, wd2, 4'(n - 1), 8'(255 - (n - 1)));
        end
      end else begin
        if (!(re2 === 1'b1 && we2 === 1'b0 && ra2 === 4'(n - 17))) begin
          bad++; $display("FAIL m0_read cyc=%0d got re=%b addr=%0h want re=1 addr=%0h", n, re2, ra2, 4'(n - 17));
        end
      end
      @(negedge clk);
    end
    wait_done(33, d2, d1);
    total++; if (d2 != 35) begin bad++; $display("FAIL m0_done_lat2 got=%0d want=35", d2); end
    total++; if (d1 != 34) begin bad++; $display("FAIL m0_done_lat1 got=%0d want=34", d1); end
    total++; if (pass2 !== 1'b1 || err2 !== 3'd0) begin bad++; $display("FAIL m0_pass2 got=%b/%0d want=1/0", pass2, err2); end
    total++; if (pass1 !== 1'b1 || err1 !== 8'd0) begin bad++; $display("FAIL m0_pass1 got=%b/%0d want=1/0", pass1, err1); end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (mem2[k] !== 8'(255 - k)) begin bad++; $display("FAIL m0_mem addr=%0d got=%0h want=%0h", k, mem2[k], 8'(255 - k)); end
    end
  endtask

  task automatic test_checker(input logic [1:0] m, input logic [7:0] e0, input logic [7:0] e1);
    int d2, d1;
    kick(m);
    wait_done(1, d2, d1);
    total++; if (mem2[0] !== e0 || mem2[1] !== e1 || mem2[15] !== e1) begin
      bad++; $display("FAIL cb_mem mode=%0d got=%0h/%0h/%0h want=%0h/%0h/%0h", m, mem2[0], mem2[1], mem2[15], e0, e1, e1);
    end
    total++; if (pass2 !== 1'b1 || pass1 !== 1'b1) begin bad++; $display("FAIL cb_pass mode=%0d got=%b%b want=11", m, pass2, pass1); end
  endtask

  task automatic test_fault();
    int d2, d1;
    fault = 1;
    kick(2'd1);
    wait_done(1, d2, d1);
    total++; if (err2 !== 3'd1 || ffa2 !== 4'd5 || pass2 !== 1'b0) begin bad++; $display("FAIL fault2 got err=%0d ffa=%0d pass=%b want err=1 ffa=5 pass=0", err2, ffa2, pass2); end
    total++; if (err1 !== 8'd1 || ffa1 !== 4'd5 || pass1 !== 1'b0) begin bad++; $display("FAIL fault1 got err=%0d ffa=%0d pass=%b want err=1 ffa=5 pass=0", err1, ffa1, pass1); end
    total++; if (done2 !== 1'b1) begin bad++; $display("FAIL fault_done got=%b want=1", done2); end
    fault = 0;
  endtask

  task automatic test_saturation();
    int d2, d1;
    fault = 2;
    kick(2'd0);
    wait_done(1, d2, d1);
    total++; if (err2 !== 3'd7 || ffa2 !== 4'd0) begin bad++; $display("FAIL sat2 got err=%0d ffa=%0d want err=7 ffa=0", err2, ffa2); end
    total++; if (err1 !== 8'd16 || ffa1 !== 4'd0) begin bad++; $display("FAIL sat1 got err=%0d ffa=%0d want err=16 ffa=0", err1, ffa1); end
    total++; if (pass2 !== 1'b0) begin bad++; $display("FAIL sat_pass got=%b want=0", pass2); end
    fault = 0;
  endtask

  task automatic test_restart_clears();
    int d2, d1;
    kick(2'd1);
    total++; if (err2 !== 3'd0 || err1 !== 8'd0 || done2 !== 1'b0 || busy2 !== 1'b1) begin
      bad++; $display("FAIL restart_clear got err=%0d/%0d done=%b busy=%b want 0/0 0 1", err2, err1, done2, busy2);
    end
    wait_done(1, d2, d1);
    total++; if (d2 != 35 || pass2 !== 1'b1) begin bad++; $display("FAIL restart_run got done@%0d pass=%b want done@35 pass=1", d2, pass2); end
  endtask

  task automatic test_reset_mid_write();
    int d2, d1;
    kick(2'd0);
    repeat (7) @(negedge clk);
    total++; if (wa2 !== 4'd7 || we2 !== 1'b1) begin bad++; $display("FAIL midw_pos got addr=%0h we=%b want addr=7 we=1", wa2, we2); end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    total++; if (busy2 !== 1'b0 || we2 !== 1'b0 || err2 !== 3'd0 || st2 !== 3'd0) begin
      bad++; $display("FAIL midw_rst got busy=%b we=%b err=%0d st=%0d want 0 0 0 0", busy2, we2, err2, st2);
    end
    total++; if (busy1 !== 1'b0 || we1 !== 1'b0 || wa1 !== 4'd0) begin bad++; $display("FAIL midw_rst1 got busy=%b we=%b addr=%0h want 0 0 0", busy1, we1, wa1); end
    kick(2'd2);
    wait_done(1, d2, d1);
    total++; if (d2 != 35 || d1 != 34) begin bad++; $display("FAIL midw_rerun_lat got=%0d/%0d want=35/34", d2, d1); end
    total++; if (pass2 !== 1'b1 || pass1 !== 1'b1) begin bad++; $display("FAIL midw_rerun_pass got=%b%b want=11", pass2, pass1); end
  endtask

  task automatic test_reset_mid_read();
    fault = 2;
    kick(2'd0);
    repeat (24) @(negedge clk);
    total++; if (err2 === 3'd0 || re2 !== 1'b1) begin bad++; $display("FAIL midr_pre got err=%0d re=%b want err>0 re=1", err2, re2); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fault = 0;
    total++; if (err2 !== 3'd0 || ffa2 !== 4'd0 || re2 !== 1'b0 || busy2 !== 1'b0) begin
      bad++; $display("FAIL midr_rst got err=%0d ffa=%0d re=%b busy=%b want 0 0 0 0", err2, ffa2, re2, busy2);
    end
    total++; if (err1 !== 8'd0 || re1 !== 1'b0) begin bad++; $display("FAIL midr_rst1 got err=%0d re=%b want 0 0", err1, re1); end
    repeat (4) @(negedge clk);
    total++; if (err2 !== 3'd0 || err1 !== 8'd0 || st2 !== 3'd0) begin bad++; $display("FAIL midr_flush got err=%0d/%0d st=%0d want 0/0/0", err2, err1, st2); end
  endtask

  task automatic test_start_in_read();
    int d2, d1;
    kick(2'd0);
    repeat (19) @(negedge clk);
    start = 1'b1;
    mode  = 2'd3;
    @(negedge clk);
    start = 1'b0;
    mode  = 2'd0;
    total++; if (st2 !== 3'd2 || ra2 !== 4'd4) begin bad++; $display("FAIL rdstart_pos got st=%0d addr=%0h want st=2 addr=4", st2, ra2); end
    wait_done(21, d2, d1);
    total++; if (d2 != 35 || d1 != 34) begin bad++; $display("FAIL rdstart_lat got=%0d/%0d want=35/34", d2, d1); end
    total++; if (pass2 !== 1'b1 || pass1 !== 1'b1) begin bad++; $display("FAIL rdstart_pass got=%b%b want=11", pass2, pass1); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
    fault = 0;
    test_reset();
    test_mode0();
    test_checker(2'd2, 8'h55, 8'hAA);
    test_checker(2'd3, 8'hAA, 8'h55);
    test_fault();
    test_saturation();
    test_restart_clears();
    test_reset_mid_write();
    test_reset_mid_read();
    test_start_in_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
